// File: rtl/lbp_stream.sv
// Streaming 3x3 Local Binary Pattern engine: reads a frame once in raster order,
// keeps two line buffers plus a 3x3 window, and emits one code per interior pixel.
module lbp_stream #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int DW     = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode_i,
  input  logic [DW-1:0]     thresh_i,
  output logic              gray_req_o,
  output logic [ADDR_W-1:0] gray_addr_o,
  input  logic              gray_ready_i,
  input  logic [DW-1:0]     gray_data_i,
  output logic              lbp_valid_o,
  output logic [ADDR_W-1:0] lbp_addr_o,
  output logic [7:0]        lbp_data_o,
  output logic              finish_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] LAST_CENTER = ADDR_W'((IMG_H - 2) * IMG_W + IMG_W - 2);
  localparam logic [ADDR_W-1:0] CENTER_OFS  = ADDR_W'(IMG_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q;
  logic [RW-1:0]       r_q;
  logic [CW-1:0]       c_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DW-1:0]       thr_q;
  logic                pvalid_q;
  logic [RW-1:0]       prow_q;
  logic [CW-1:0]       pcol_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DW-1:0]       win_q [3][3];
  logic [DW-1:0]       lb0 [IMG_W];
  logic [DW-1:0]       lb1 [IMG_W];
  logic                lbp_valid_q;
  logic [ADDR_W-1:0]   lbp_addr_q;
  logic [7:0]          lbp_data_q;
  logic                finish_q;

  logic                last_req;
  logic                interior_d;
  logic [DW-1:0]       top_d, mid_d, center_d;
  logic [DW:0]         limit_d;
  logic [DW-1:0]       nbr_d [8];
  logic [7:0]          code_d;

  // Requests are gated combinationally so none is ever issued while memory is busy.
  assign gray_req_o  = (state_q == RUN) && gray_ready_i;
  assign gray_addr_o = addr_q;
  assign lbp_valid_o = lbp_valid_q;
  assign lbp_addr_o  = lbp_addr_q;
  assign lbp_data_o  = lbp_data_q;
  assign finish_o    = finish_q;

  assign last_req   = (r_q == RW'(IMG_H - 1)) && (c_q == CW'(IMG_W - 1));
  assign interior_d = pvalid_q && (prow_q >= RW'(2)) && (pcol_q >= CW'(2));

  // The returned pixel forms the right column of the shifted window; the
  // center is the old middle-right element.
  always_comb begin
    top_d    = lb1[pcol_q];
    mid_d    = lb0[pcol_q];
    center_d = win_q[1][2];
    nbr_d[0] = win_q[0][1];
    nbr_d[1] = win_q[0][2];
    nbr_d[2] = top_d;
    nbr_d[3] = win_q[1][1];
    nbr_d[4] = mid_d;
    nbr_d[5] = win_q[2][1];
    nbr_d[6] = win_q[2][2];
    nbr_d[7] = gray_data_i;
    limit_d  = {1'b0, center_d} + {1'b0, thr_q};
    code_d   = '0;
    for (int k = 0; k < 8; k++) begin
      code_d[k] = ({1'b0, nbr_d[k]} >= limit_d);
    end
  end

  always_ff @(posedge clk) begin
    if (pvalid_q) begin
      lb1[pcol_q] <= lb0[pcol_q];
      lb0[pcol_q] <= gray_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      r_q         <= '0;
      c_q         <= '0;
      addr_q      <= '0;
      thr_q       <= '0;
      pvalid_q    <= 1'b0;
      prow_q      <= '0;
      pcol_q      <= '0;
      paddr_q     <= '0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= '0;
      finish_q    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (gray_ready_i) begin
            state_q <= RUN;
            thr_q   <= mode_i ? thresh_i : '0;
            r_q     <= '0;
            c_q     <= '0;
            addr_q  <= '0;
          end
        end
        RUN: begin
          if (gray_ready_i) begin
            addr_q <= addr_q + 1'b1;
            if (c_q == CW'(IMG_W - 1)) begin
              c_q <= '0;
              r_q <= r_q + 1'b1;
            end else begin
              c_q <= c_q + 1'b1;
            end
            if (last_req) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (lbp_valid_q && (lbp_addr_q == LAST_CENTER)) begin
            state_q  <= DONE;
            finish_q <= 1'b1;
          end
        end
        default: finish_q <= 1'b1;
      endcase

      pvalid_q <= gray_req_o;
      prow_q   <= r_q;
      pcol_q   <= c_q;
      paddr_q  <= addr_q;

      if (pvalid_q) begin
        for (int i = 0; i < 3; i++) begin
          win_q[i][0] <= win_q[i][1];
          win_q[i][1] <= win_q[i][2];
        end
        win_q[0][2] <= top_d;
        win_q[1][2] <= mid_d;
        win_q[2][2] <= gray_data_i;
      end

      lbp_valid_q <= interior_d;
      if (interior_d) begin
        lbp_addr_q <= paddr_q - CENTER_OFS;
        lbp_data_q <= code_d;
      end
    end
  end

endmodule

// File: tb/tb_lbp_stream.sv
// Scoreboard bench for lbp_stream: a memory model serves pixel reads, a
// neighbourhood reference model fills the expected queue, a monitor pops it.
module tb_lbp_stream;

  localparam int W    = 16;
  localparam int H    = 12;
  localparam int AW   = 8;
  localparam int NOUT = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          modeI = 1'b0;
  logic [7:0]    threshI = '0;
  logic          grayReq;
  logic [AW-1:0] grayAddr;
  logic          grayReady = 1'b0;
  logic [7:0]    grayData = '0;
  logic          lbpValid;
  logic [AW-1:0] lbpAddr;
  logic [7:0]    lbpData;
  logic          finish;

  int img [W*H];
  int expAddr [$];
  int expCode [$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int reqCount, outCount, firstReqCyc, firstValCyc, lastValCyc, finishCyc;
  bit finishSeen;
  bit haveReq = 1'b0;
  int reqAddrLatched = 0;

  always #5 clk = ~clk;

  lbp_stream #(.IMG_W(W), .IMG_H(H), .DW(8), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .mode_i(modeI), .thresh_i(threshI),
    .gray_req_o(grayReq), .gray_addr_o(grayAddr), .gray_ready_i(grayReady),
    .gray_data_i(grayData), .lbp_valid_o(lbpValid), .lbp_addr_o(lbpAddr),
    .lbp_data_o(lbpData), .finish_o(finish)
  );

  function automatic void checkOutput(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, actual, actual, expected, expected, cyc);
    end
  endfunction

  // Reference: each code compares the eight neighbours of every interior pixel
  // against center + threshold using ordinary integers.
  function automatic void buildExpected(bit m, int th);
    int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    expAddr.delete();
    expCode.delete();
    for (int r = 1; r < H - 1; r++) begin
      for (int c = 1; c < W - 1; c++) begin
        int lim = img[r*W + c] + (m ? th : 0);
        int code = 0;
        for (int k = 0; k < 8; k++) begin
          if (img[(r + dr[k])*W + c + dc[k]] >= lim) code = code | (1 << k);
        end
        expAddr.push_back(r*W + c);
        expCode.push_back(code);
      end
    end
  endfunction

  function automatic void fillImage(int pat);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (pat)
          0: img[r*W + c] = (r + c + 240) % 256;
          1: img[r*W + c] = 'h40;
          2: img[r*W + c] = ((r + c) % 2 == 1) ? 'hFF : 'hF0;
          3: img[r*W + c] = (r == 4 && c == 6) ? 'hFF : 0;
          4: img[r*W + c] = $urandom_range(0, 255);
          5: img[r*W + c] = $urandom_range(100, 140);
          default: ;
        endcase
      end
    end
  endfunction

  always @(posedge clk) begin
    cyc++;
    grayData <= haveReq ? 8'(img[reqAddrLatched]) : 8'($urandom);
  end

  // Monitor: request legality, memory address capture, and scoreboard pops.
  always @(negedge clk) begin
    haveReq = 1'b0;
    if (!reset) begin
      if (!grayReady) checkOutput("reqWhileStalled", int'(grayReq), 0);
      if (grayReq) begin
        checkOutput("reqAddr", int'(grayAddr), reqCount);
        if (reqCount == 0) firstReqCyc = cyc;
        reqCount++;
        if (int'(grayAddr) < W*H) begin
          haveReq = 1'b1;
          reqAddrLatched = int'(grayAddr);
        end
      end
      if (lbpValid) begin
        if (expAddr.size() == 0) begin
          checkOutput("extraValid", int'(lbpValid), 0);
        end else begin
          checkOutput("lbpAddr", int'(lbpAddr), expAddr.pop_front());
          checkOutput("lbpData", int'(lbpData), expCode.pop_front());
        end
        if (outCount == 0) firstValCyc = cyc;
        outCount++;
        lastValCyc = cyc;
      end
      if (finish && !finishSeen) begin
        finishSeen = 1'b1;
        finishCyc = cyc;
      end
    end
  end

  task automatic checkResetState(string tag);
    checkOutput({tag, "_gray_req"}, int'(grayReq), 0);
    checkOutput({tag, "_gray_addr"}, int'(grayAddr), 0);
    checkOutput({tag, "_lbp_valid"}, int'(lbpValid), 0);
    checkOutput({tag, "_lbp_addr"}, int'(lbpAddr), 0);
    checkOutput({tag, "_lbp_data"}, int'(lbpData), 0);
    checkOutput({tag, "_finish"}, int'(finish), 0);
  endtask

  // pat 6 reuses the previous image; resetAt > 0 aborts the frame with a reset.
  task automatic applyStimulus(input int pat, input bit m, input int th,
                               input int stallPct, input int resetAt);
    int budget = 0;
    bit aborted = 1'b0;
    reset = 1'b1;
    grayReady = 1'b0;
    fillImage(pat);
    buildExpected(m, th);
    reqCount = 0; outCount = 0; finishSeen = 1'b0;
    firstReqCyc = -1; firstValCyc = -1; lastValCyc = -1; finishCyc = -1;
    modeI = m;
    threshI = 8'(th);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    while (!finishSeen && budget < 3000) begin
      @(posedge clk);
      #1 budget++;
      grayReady = ($urandom_range(0, 99) >= stallPct);
      if (reqCount > 0) begin
        modeI = 1'($urandom);
        threshI = 8'($urandom);
      end
      if (resetAt > 0 && reqCount >= resetAt) begin
        reset = 1'b1;
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      @(negedge clk);
      checkResetState("midReset");
      expAddr.delete();
      expCode.delete();
      return;
    end
    checkOutput("frameCompleted", int'(finishSeen), 1);
    checkOutput("outCount", outCount, NOUT);
    checkOutput("queueDrained", expAddr.size(), 0);
    checkOutput("finishDelay", finishCyc - lastValCyc, 1);
    if (stallPct == 0) checkOutput("firstLatency", firstValCyc - firstReqCyc, 2*W + 4);
    grayReady = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("finishSticky", int'(finish), 1);
      checkOutput("noReqAfterDone", int'(grayReq), 0);
    end
  endtask

  initial begin
    @(negedge clk);
    checkResetState("reset");
    applyStimulus(0, 1'b0, 0, 0, 0);
    applyStimulus(1, 1'b0, 0, 0, 0);
    applyStimulus(1, 1'b1, 1, 0, 0);
    applyStimulus(2, 1'b1, 'h20, 0, 0);
    applyStimulus(3, 1'b0, 0, 0, 0);
    applyStimulus(0, 1'b0, 0, 50, 0);
    applyStimulus(4, 1'b0, 0, 50, 0);
    applyStimulus(5, 1'b1, $urandom_range(1, 20), 50, 0);
    applyStimulus(4, 1'b1, $urandom_range(0, 255), 30, 0);
    applyStimulus(5, 1'b0, 0, 20, 100);
    applyStimulus(6, 1'b0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
